// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan display: digit count and
// active-low segment patterns ordered {a,b,c,d,e,f,g}.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h60;
    localparam logic [6:0] SEG_C     = 7'h31;
    localparam logic [6:0] SEG_D     = 7'h42;
    localparam logic [6:0] SEG_E     = 7'h30;
    localparam logic [6:0] SEG_F     = 7'h38;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_scan_display_if.sv
// Display-side bundle: the value to show plus the active-low segment and
// digit-enable drives. There is no handshake; data is sampled live each cycle.
interface seg7_scan_display_if;

    logic [31:0] data;
    logic [7:0]  cathode;
    logic [7:0]  anode;

    modport master (output data, input cathode, input anode);
    modport slave  (input data, output cathode, output anode);

endinterface

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern {a..g}.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed hex display driver: a prescaler sets the dwell per
// digit, a digit index walks AN0..AN7, and outputs are registered.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter  int DIV_COUNT = 100000,
    localparam int CNT_W     = $clog2(DIV_COUNT) + 1
) (
    input logic clock,
    input logic reset,
    seg7_scan_display_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0] prescale;
    logic [IDX_W-1:0] index;
    logic [3:0]       nibble;
    logic [6:0]       seg;
    logic             wrap;

    assign wrap   = (prescale == CNT_W'(DIV_COUNT - 1));
    assign nibble = bus.data[{index, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (seg)
    );

    // Outputs reflect the index before this edge's increment, so digit 0 is
    // shown on the first edge after release and every digit gets a full dwell.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescale    <= '0;
            index       <= '0;
            bus.anode   <= 8'hFF;
            bus.cathode <= {SEG_BLANK, 1'b1};
        end else begin
            prescale    <= wrap ? '0 : prescale + 1'b1;
            if (wrap) index <= index + 1'b1;
            bus.anode   <= ~(8'd1 << index);
            bus.cathode <= {seg, 1'b1};
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: a DIV_COUNT=4 and a DIV_COUNT=1
// instance run side by side on the same clock, reset and data.
module tb_seg7_scan_display;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  seg7_scan_display_if if4 ();
  seg7_scan_display_if if1 ();

  seg7_scan_display #(.DIV_COUNT(4)) dut4 (
    .clock (clk),
    .reset (rst_n),
    .bus   (if4.slave)
  );

  seg7_scan_display #(.DIV_COUNT(1)) dut1 (
    .clock (clk),
    .reset (rst_n),
    .bus   (if1.slave)
  );

  // cathode bytes including DP=1, hand-copied from the decode table
  logic [7:0] seg_tab [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_data(input logic [31:0] d);
    if4.data = d;
    if1.data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // digit shown on edge number cyc (1-based since reset release)
  function automatic int exp_idx(input int div);
    return ((cyc - 1) / div) % 8;
  endfunction

  function automatic logic [7:0] exp_an(input int div);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << exp_idx(div));
  endfunction

  function automatic logic [7:0] exp_ca(input int div);
    logic [31:0] d;
    logic [3:0]  nib;
    d   = if4.data;
    nib = d[exp_idx(div) * 4 +: 4];
    return seg_tab[nib];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_an4"}, if4.anode,   exp_an(4));
    chk({tag, "_ca4"}, if4.cathode, exp_ca(4));
    chk({tag, "_an1"}, if1.anode,   exp_an(1));
    chk({tag, "_ca1"}, if1.cathode, exp_ca(1));
  endtask

  task automatic check_blank(input string tag);
    chk({tag, "_an4"}, if4.anode,   8'hFF);
    chk({tag, "_ca4"}, if4.cathode, 8'hFF);
    chk({tag, "_an1"}, if1.anode,   8'hFF);
    chk({tag, "_ca1"}, if1.cathode, 8'hFF);
  endtask

  // directed sequence
  logic [7:0] letters_exp [8] = '{8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h03, 8'h09};
  logic [7:0] scan_exp    [8] = '{8'h01, 8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F};

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1'b1;
    set_data(32'h12345678);

    // asynchronous reset, no clock edge yet
    #1 rst_n = 1'b0;
    #1 check_blank("reset_async");
    repeat (3) @(posedge clk);
    #1 check_blank("reset_hold");

    // scan order with 12345678
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 36; k++) begin
      tick();
      check_all("scan");
      chk("scan_digit", if4.cathode, scan_exp[exp_idx(4)]);
    end

    // all F then all 0, change visible one edge later
    @(negedge clk);
    set_data(32'hFFFFFFFF);
    for (int k = 0; k < 32; k++) begin
      tick();
      chk("allf_ca4", if4.cathode, 8'h71);
      check_all("allf");
    end
    @(negedge clk);
    set_data(32'h00000000);
    tick();
    chk("zero_first_ca4", if4.cathode, 8'h03);
    chk("zero_first_ca1", if1.cathode, 8'h03);
    for (int k = 0; k < 31; k++) begin
      tick();
      check_all("zero");
    end

    // letters
    @(negedge clk);
    set_data(32'h90ABCDEF);
    for (int k = 0; k < 32; k++) begin
      tick();
      chk("letter_digit", if4.cathode, letters_exp[exp_idx(4)]);
      chk("letter_dp", {7'd0, if4.cathode[0]}, 8'd1);
      check_all("letter");
    end

    // mid-scan reset while digit 5 is lit
    for (int n = 0; n < 40 && exp_idx(4) != 5; n++) tick();
    chk("mid_an_before", if4.anode, 8'hDF);
    #2 rst_n = 1'b0;
    #1 check_blank("mid_reset_async");
    @(posedge clk);
    #1 check_blank("mid_reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("restart_dwell_an4", if4.anode, 8'hFE);
      check_all("restart");
    end
    tick();
    chk("restart_next_an4", if4.anode, 8'hFD);
    check_all("restart_next");

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
